dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 tb/tb_dmem_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port (A: pipeline MEM stage, B: debug/loader) arbiter in front of a 64-byte data memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default build gives port A fixed priority.
module dmem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        A_Req,
    input  logic        A_Write,
    input  logic [63:0] A_Addr,
    input  logic [63:0] A_WData,
    output logic        A_Ack,
    output logic        A_Err,
    output logic [63:0] A_RData,
    input  logic        B_Req,
    input  logic        B_Write,
    input  logic [63:0] B_Addr,
    input  logic [63:0] B_WData,
    output logic        B_Ack,
    output logic        B_Err,
    output logic [63:0] B_RData,
    output logic [63:0] Mem_Addr,
    output logic [63:0] Write_Data,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [63:0] Read_Data
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic        grant_b_q, grant_b_d;
    logic        wr_q, wr_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] a_rdata_q, a_rdata_d;
    logic [63:0] b_rdata_q, b_rdata_d;
`ifdef DMEM_ARB_RR_EN
    logic        last_b_q, last_b_d;
`endif

    logic pick_b;
    logic in_range;
    logic mem_active;
    logic done;

    always_comb begin
        state_d   = state_q;
        grant_b_d = grant_b_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
`ifdef DMEM_ARB_RR_EN
        last_b_d  = last_b_q;
        pick_b    = B_Req && (!A_Req || !last_b_q);
`else
        pick_b    = B_Req && !A_Req;
`endif
        in_range  = (addr_q <= 64'd56);

        case (state_q)
            IDLE: begin
                if (A_Req || B_Req) begin
                    state_d   = ACCESS;
                    grant_b_d = pick_b;
                    wr_d      = pick_b ? B_Write : A_Write;
                    addr_d    = pick_b ? B_Addr  : A_Addr;
                    wdata_d   = pick_b ? B_WData : A_WData;
`ifdef DMEM_ARB_RR_EN
                    last_b_d  = pick_b;
`endif
                end
            end
            ACCESS: begin
                state_d = DONE;
                if (!wr_q && in_range) begin
                    if (grant_b_q) begin
                        b_rdata_d = Read_Data;
                    end else begin
                        a_rdata_d = Read_Data;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes are gated by reset so an aborted transaction never touches memory or acks.
    always_comb begin
        mem_active = (state_q == ACCESS) && in_range && !reset;
        done       = (state_q == DONE) && !reset;
        MemWrite   = mem_active && wr_q;
        MemRead    = mem_active && !wr_q;
        Mem_Addr   = addr_q;
        Write_Data = wdata_q;
        A_Ack      = done && !grant_b_q;
        B_Ack      = done && grant_b_q;
        A_Err      = done && !grant_b_q && !in_range;
        B_Err      = done && grant_b_q && !in_range;
        A_RData    = a_rdata_q;
        B_RData    = b_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_b_q <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
            last_b_q  <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            grant_b_q <= grant_b_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
`ifdef DMEM_ARB_RR_EN
            last_b_q  <= last_b_d;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a 64-byte little-endian memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        A_Req = 1'b0, A_Write = 1'b0;
    logic [63:0] A_Addr = '0, A_WData = '0;
    logic        A_Ack, A_Err;
    logic [63:0] A_RData;
    logic        B_Req = 1'b0, B_Write = 1'b0;
    logic [63:0] B_Addr = '0, B_WData = '0;
    logic        B_Ack, B_Err;
    logic [63:0] B_RData;
    logic [63:0] Mem_Addr, Write_Data;
    logic        MemWrite, MemRead;
    logic [63:0] Read_Data;

    int tests = 0;
    int failed = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    logic [63:0] wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic [7:0]  mem [64];

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .A_Req(A_Req), .A_Write(A_Write), .A_Addr(A_Addr), .A_WData(A_WData),
        .A_Ack(A_Ack), .A_Err(A_Err), .A_RData(A_RData),
        .B_Req(B_Req), .B_Write(B_Write), .B_Addr(B_Addr), .B_WData(B_WData),
        .B_Ack(B_Ack), .B_Err(B_Err), .B_RData(B_RData),
        .Mem_Addr(Mem_Addr), .Write_Data(Write_Data),
        .MemWrite(MemWrite), .MemRead(MemRead), .Read_Data(Read_Data)
    );

    always_comb begin
        Read_Data = '0;
        if (Mem_Addr <= 64'd56) begin
            for (int i = 0; i < 8; i++) begin
                Read_Data[8*i +: 8] = mem[int'(Mem_Addr[5:0]) + i];
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
        end else if (MemWrite && Mem_Addr <= 64'd56) begin
            for (int i = 0; i < 8; i++) mem[int'(Mem_Addr[5:0]) + i] <= Write_Data[8*i +: 8];
        end
    end

    always @(negedge clk) begin
        if (MemWrite) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= Mem_Addr;
            wr_data <= Write_Data;
        end
        if (MemRead) rd_cnt <= rd_cnt + 1;
    end

    // Called at posedge+1 in an IDLE cycle; returns at posedge+1 of the following IDLE cycle.
    task automatic run_txn(input logic port_b, input logic wr, input logic [63:0] addr,
                           input logic [63:0] wd, output int cyc, output logic err);
        cyc = 0;
        err = 1'b0;
        if (port_b) begin
            B_Req = 1'b1; B_Write = wr; B_Addr = addr; B_WData = wd;
        end else begin
            A_Req = 1'b1; A_Write = wr; A_Addr = addr; A_WData = wd;
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if ((port_b ? B_Ack : A_Ack) === 1'b1) begin
                cyc = k;
                err = port_b ? B_Err : A_Err;
                break;
            end
        end
        @(posedge clk);
        #1;
        A_Req = 1'b0;
        B_Req = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        A_Req = 1'b0;
        B_Req = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({A_Ack, B_Ack, A_Err, B_Err, MemWrite, MemRead} !== 6'b0) begin
            failed++;
            $display("FAIL reset_strobes: got %b expected 000000",
                     {A_Ack, B_Ack, A_Err, B_Err, MemWrite, MemRead});
        end
        tests++;
        if (A_RData !== 64'd0) begin
            failed++; $display("FAIL reset_a_rdata: got %h expected 0", A_RData);
        end
        tests++;
        if (B_RData !== 64'd0) begin
            failed++; $display("FAIL reset_b_rdata: got %h expected 0", B_RData);
        end
        tests++;
        if (Mem_Addr !== 64'd0) begin
            failed++; $display("FAIL reset_mem_addr: got %h expected 0", Mem_Addr);
        end
        tests++;
        if (Write_Data !== 64'd0) begin
            failed++; $display("FAIL reset_write_data: got %h expected 0", Write_Data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_a();
        int cyc, wc0, rc0;
        logic err;
        wc0 = wr_cnt;
        rc0 = rd_cnt;
        run_txn(1'b0, 1'b1, 64'd8, 64'h1122334455667788, cyc, err);
        tests++;
        if (cyc !== 3) begin
            failed++; $display("FAIL store_a_ack_cycle: got %0d expected 3", cyc);
        end
        tests++;
        if (err !== 1'b0) begin
            failed++; $display("FAIL store_a_err: got %b expected 0", err);
        end
        tests++;
        if (wr_cnt - wc0 !== 1 || rd_cnt - rc0 !== 0) begin
            failed++;
            $display("FAIL store_a_strobes: got wr=%0d rd=%0d expected wr=1 rd=0",
                     wr_cnt - wc0, rd_cnt - rc0);
        end
        tests++;
        if (wr_addr !== 64'd8 || wr_data !== 64'h1122334455667788) begin
            failed++;
            $display("FAIL store_a_bus: got addr=%h data=%h expected addr=8 data=1122334455667788",
                     wr_addr, wr_data);
        end
        tests++;
        if (Mem_Addr !== 64'd8 || MemWrite !== 1'b0) begin
            failed++;
            $display("FAIL store_a_hold: got addr=%h we=%b expected addr=8 we=0", Mem_Addr, MemWrite);
        end
    endtask

    task automatic test_load_b();
        int cyc, wc0, rc0;
        logic err;
        wc0 = wr_cnt;
        rc0 = rd_cnt;
        run_txn(1'b1, 1'b0, 64'd8, 64'd0, cyc, err);
        tests++;
        if (cyc !== 3 || err !== 1'b0) begin
            failed++; $display("FAIL load_b_ack: got cyc=%0d err=%b expected cyc=3 err=0", cyc, err);
        end
        tests++;
        if (rd_cnt - rc0 !== 1 || wr_cnt - wc0 !== 0) begin
            failed++;
            $display("FAIL load_b_strobes: got rd=%0d wr=%0d expected rd=1 wr=0",
                     rd_cnt - rc0, wr_cnt - wc0);
        end
        tests++;
        if (B_RData !== 64'h1122334455667788) begin
            failed++; $display("FAIL load_b_rdata: got %h expected 1122334455667788", B_RData);
        end
        tests++;
        if (A_RData !== 64'd0) begin
            failed++; $display("FAIL load_b_a_rdata: got %h expected 0", A_RData);
        end
    endtask

    task automatic test_rdata_hold();
        int cyc;
        logic err;
        run_txn(1'b0, 1'b0, 64'd8, 64'd0, cyc, err);
        tests++;
        if (A_RData !== 64'h1122334455667788) begin
            failed++; $display("FAIL load_a_rdata: got %h expected 1122334455667788", A_RData);
        end
        run_txn(1'b0, 1'b1, 64'd16, 64'h0123456789ABCDEF, cyc, err);
        tests++;
        if (A_RData !== 64'h1122334455667788) begin
            failed++; $display("FAIL store_keeps_a_rdata: got %h expected 1122334455667788", A_RData);
        end
        run_txn(1'b1, 1'b0, 64'd16, 64'd0, cyc, err);
        tests++;
        if (B_RData !== 64'h0123456789ABCDEF) begin
            failed++; $display("FAIL load_b16_rdata: got %h expected 0123456789abcdef", B_RData);
        end
    endtask

    task automatic test_range();
        int cyc, wc0, rc0;
        logic err;
        wc0 = wr_cnt;
        rc0 = rd_cnt;
        run_txn(1'b0, 1'b0, 64'd57, 64'd0, cyc, err);
        tests++;
        if (cyc !== 3 || err !== 1'b1) begin
            failed++; $display("FAIL range57_ack: got cyc=%0d err=%b expected cyc=3 err=1", cyc, err);
        end
        tests++;
        if (wr_cnt - wc0 !== 0 || rd_cnt - rc0 !== 0) begin
            failed++;
            $display("FAIL range57_strobes: got wr=%0d rd=%0d expected 0 0", wr_cnt - wc0, rd_cnt - rc0);
        end
        tests++;
        if (A_RData !== 64'h1122334455667788) begin
            failed++; $display("FAIL range57_a_rdata: got %h expected 1122334455667788", A_RData);
        end
        wc0 = wr_cnt;
        run_txn(1'b0, 1'b1, 64'd56, 64'hA5A50000FFFF5A5A, cyc, err);
        tests++;
        if (err !== 1'b0 || wr_cnt - wc0 !== 1) begin
            failed++;
            $display("FAIL range56_store: got err=%b wr=%0d expected err=0 wr=1", err, wr_cnt - wc0);
        end
        run_txn(1'b1, 1'b0, 64'd56, 64'd0, cyc, err);
        tests++;
        if (err !== 1'b0 || B_RData !== 64'hA5A50000FFFF5A5A) begin
            failed++;
            $display("FAIL range56_load: got err=%b data=%h expected err=0 data=a5a50000ffff5a5a",
                     err, B_RData);
        end
        wc0 = wr_cnt;
        run_txn(1'b1, 1'b1, 64'h8000000000000008, 64'hFFFFFFFFFFFFFFFF, cyc, err);
        tests++;
        if (cyc !== 3 || err !== 1'b1 || wr_cnt - wc0 !== 0) begin
            failed++;
            $display("FAIL range_high_store: got cyc=%0d err=%b wr=%0d expected cyc=3 err=1 wr=0",
                     cyc, err, wr_cnt - wc0);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] grant;
        logic [3:0] exp_grant;
        int ack_cyc [4];
        int n;
`ifdef DMEM_ARB_RR_EN
        exp_grant = 4'b1010;
`else
        exp_grant = 4'b0000;
`endif
        grant = '0;
        n = 0;
        for (int i = 0; i < 4; i++) ack_cyc[i] = 0;
        pulse_reset();
        A_Req = 1'b1; A_Write = 1'b0; A_Addr = 64'd0;
        B_Req = 1'b1; B_Write = 1'b0; B_Addr = 64'd8;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (A_Ack === 1'b1 || B_Ack === 1'b1) begin
                grant[n] = B_Ack;
                ack_cyc[n] = k;
                n++;
            end
            if (n == 4) break;
        end
        @(posedge clk);
        #1;
        A_Req = 1'b0;
        B_Req = 1'b0;
        tests++;
        if (n !== 4) begin
            failed++; $display("FAIL b2b_count: got %0d acks expected 4", n);
        end
        tests++;
        if (grant !== exp_grant) begin
            failed++; $display("FAIL b2b_grants: got %b expected %b (bit0 first, 1=B)", grant, exp_grant);
        end
        tests++;
        if (ack_cyc[0] !== 3 || ack_cyc[3] !== 12) begin
            failed++;
            $display("FAIL b2b_timing: got first=%0d last=%0d expected first=3 last=12",
                     ack_cyc[0], ack_cyc[3]);
        end
    endtask

    task automatic test_reset_abort();
        int cyc, wc0, b_acks;
        logic err;
        pulse_reset();
        wc0 = wr_cnt;
        B_Req = 1'b1; B_Write = 1'b1; B_Addr = 64'd16; B_WData = 64'hDEADBEEF0BADF00D;
        @(posedge clk);
        #1;
        reset = 1'b1;
        B_Req = 1'b0;
        @(negedge clk);
        tests++;
        if (MemWrite !== 1'b0) begin
            failed++; $display("FAIL abort_memwrite: got %b expected 0", MemWrite);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        b_acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (B_Ack === 1'b1) b_acks++;
        end
        @(posedge clk);
        #1;
        tests++;
        if (b_acks !== 0 || wr_cnt - wc0 !== 0) begin
            failed++;
            $display("FAIL abort_no_ack: got acks=%0d wr=%0d expected 0 0", b_acks, wr_cnt - wc0);
        end
        tests++;
        if (Mem_Addr !== 64'd0) begin
            failed++; $display("FAIL abort_mem_addr: got %h expected 0", Mem_Addr);
        end
        run_txn(1'b1, 1'b1, 64'd16, 64'hDEADBEEF0BADF00D, cyc, err);
        tests++;
        if (cyc !== 3 || err !== 1'b0 || wr_cnt - wc0 !== 1 || wr_addr !== 64'd16) begin
            failed++;
            $display("FAIL abort_reissue: got cyc=%0d err=%b wr=%0d addr=%h expected cyc=3 err=0 wr=1 addr=10",
                     cyc, err, wr_cnt - wc0, wr_addr);
        end
        run_txn(1'b1, 1'b0, 64'd16, 64'd0, cyc, err);
        tests++;
        if (B_RData !== 64'hDEADBEEF0BADF00D) begin
            failed++; $display("FAIL abort_readback: got %h expected deadbeef0badf00d", B_RData);
        end
    endtask

    initial begin
        test_reset();
        test_store_a();
        test_load_b();
        test_rdata_hold();
        test_range();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
